// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide single-cycle data memory
// Optional misalignment trap: define MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int REGSIZE = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W+1:0]   req_addr,
  input  logic [REGSIZE-1:0]  req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REGSIZE-1:0]  resp_rdata,
  output logic                resp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [REGSIZE-1:0]  mem_wdata,
  input  logic [REGSIZE-1:0]  mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_RMW_WR, S_WRITE, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [ADDR_W+1:0]    addr_q, addr_d;
  logic [REGSIZE-1:0]   wdata_q, wdata_d;
  logic [REGSIZE-1:0]   merge_q, merge_d;
  logic [REGSIZE-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [REGSIZE-1:0]   load_val;
  logic [REGSIZE-1:0]   merged;
  logic                 rd_raw, wr_raw;

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = lo[0];
      OP_LW, OP_SW:         misaligned = (lo != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  endfunction
`endif

  // Lane extraction from the live memory word, little-endian byte order.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'h0000, lane_h};
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'h000000, lane_b};
      default: load_val = mem_rdata;
    endcase
  end

  // Replace the addressed byte/halfword in the word captured during RMW_RD.
  always_comb begin
    merged = merge_q;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rd_raw     = 1'b0;
    wr_raw     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          case (req_op)
            OP_SW:        state_d = S_WRITE;
            OP_SH, OP_SB: state_d = S_RMW_RD;
            default:      state_d = S_LOAD;
          endcase
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(req_op, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_LOAD: begin
        rd_raw  = 1'b1;
        rdata_d = load_val;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        rd_raw  = 1'b1;
        merge_d = mem_rdata;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        wr_raw    = 1'b1;
        mem_wdata = merged;
        state_d   = S_RESP;
      end
      S_WRITE: begin
        wr_raw    = 1'b1;
        mem_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are masked by reset so an abandoned request never reaches memory.
  assign mem_read   = rd_raw & ~reset;
  assign mem_write  = wr_raw & ~reset;
  assign mem_addr   = (rd_raw | wr_raw) ? addr_q[ADDR_W+1:2] : '0;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
